// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with write-back source selection, load lane extraction and EX forwarding.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              iStall,
  input  logic              iFlush,
  input  logic              iValid,
  input  logic              iRegWrite,
  input  logic [2:0]        iMemToReg,
  input  logic [ADDR_W-1:0] iRegAddr,
  input  logic [DATA_W-1:0] iALUResult,
  input  logic [DATA_W-1:0] iMemData,
  input  logic [DATA_W-1:0] iPCPlus4,
  input  logic              iHiLoWrite,
  input  logic [DATA_W-1:0] iHi,
  input  logic [DATA_W-1:0] iLo,
  output logic              cRegWrite,
  output logic [DATA_W-1:0] RegWriteData,
  output logic [ADDR_W-1:0] RegWriteAddress,
  output logic              HiLoWrite,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  output logic              oFwdValid,
  output logic [ADDR_W-1:0] oFwdAddr,
  output logic [DATA_W-1:0] oFwdData
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       oRetireCount
`endif
);

  typedef enum logic [2:0] {
    WB_ALU    = 3'b000,
    WB_WORD   = 3'b001,
    WB_HALF_S = 3'b010,
    WB_HALF_U = 3'b011,
    WB_BYTE_S = 3'b100,
    WB_BYTE_U = 3'b101,
    WB_LINK   = 3'b110,
    WB_RSVD   = 3'b111
  } wb_sel_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    wb_sel_t           memtoreg;
    logic              hilowrite;
    logic [ADDR_W-1:0] regaddr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] memdata;
    logic [DATA_W-1:0] pcplus4;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } stage_t;

  stage_t            r_stage;
  stage_t            w_stage_in;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_reg_we;

  always_comb begin
    w_stage_in.valid     = iValid;
    w_stage_in.regwrite  = iRegWrite;
    w_stage_in.memtoreg  = wb_sel_t'(iMemToReg);
    w_stage_in.hilowrite = iHiLoWrite;
    w_stage_in.regaddr   = iRegAddr;
    w_stage_in.alu       = iALUResult;
    w_stage_in.memdata   = iMemData;
    w_stage_in.pcplus4   = iPCPlus4;
    w_stage_in.hi        = iHi;
    w_stage_in.lo        = iLo;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // A flush only kills the control bits; the data fields are don't-care inside a bubble.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stage <= '0;
    end else if (iFlush) begin
      r_stage.valid     <= 1'b0;
      r_stage.regwrite  <= 1'b0;
      r_stage.memtoreg  <= WB_ALU;
      r_stage.hilowrite <= 1'b0;
    end else if (!iStall) begin
      r_stage <= w_stage_in;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_byte = r_stage.memdata[7:0];
    case (r_stage.alu[1:0])
      2'd1:    w_byte = r_stage.memdata[15:8];
      2'd2:    w_byte = r_stage.memdata[23:16];
      2'd3:    w_byte = r_stage.memdata[31:24];
      default: w_byte = r_stage.memdata[7:0];
    endcase
    // Halfword loads ignore offset bit 0.
    w_half = r_stage.alu[1] ? r_stage.memdata[31:16] : r_stage.memdata[15:0];
  end

  always_comb begin
    w_wb_data = r_stage.alu;
    case (r_stage.memtoreg)
      WB_ALU:    w_wb_data = r_stage.alu;
      WB_WORD:   w_wb_data = r_stage.memdata;
      WB_HALF_S: w_wb_data = {{(DATA_W-16){w_half[15]}}, w_half};
      WB_HALF_U: w_wb_data = {{(DATA_W-16){1'b0}}, w_half};
      WB_BYTE_S: w_wb_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      WB_BYTE_U: w_wb_data = {{(DATA_W-8){1'b0}}, w_byte};
      WB_LINK:   w_wb_data = r_stage.pcplus4 + DATA_W'(4);
      WB_RSVD:   w_wb_data = r_stage.alu;
      default:   w_wb_data = r_stage.alu;
    endcase
  end

  // Writes to $0 are dropped, but the address still reaches the port.
  assign w_reg_we        = r_stage.valid & r_stage.regwrite & (r_stage.regaddr != '0);

  assign cRegWrite       = w_reg_we;
  assign RegWriteData    = w_wb_data;
  assign RegWriteAddress = r_stage.regaddr;
  assign HiLoWrite       = r_stage.valid & r_stage.hilowrite;
  assign Hi              = r_stage.hi;
  assign Lo              = r_stage.lo;
  assign oFwdValid       = w_reg_we;
  assign oFwdAddr        = r_stage.regaddr;
  assign oFwdData        = w_wb_data;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Counted on entry only, so a stalled instruction is seen once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_retire_cnt <= '0;
    end else if (!iFlush && !iStall && iValid) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign oRetireCount = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: directed cases followed by random traffic against a reference model.
// Covers the WB_RETIRE_CNT_EN counter when that macro is defined.
module tb_mem_wb_writeback;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic [2:0]  sel;
    logic [4:0]  addr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
    logic        hlw;
    logic [31:0] hi;
    logic [31:0] lo;
  } instr_t;

  logic        Clk = 1'b0;
  logic        Reset, iStall, iFlush, iValid, iRegWrite, iHiLoWrite;
  logic [2:0]  iMemToReg;
  logic [4:0]  iRegAddr;
  logic [31:0] iALUResult, iMemData, iPCPlus4, iHi, iLo;
  logic        cRegWrite, HiLoWrite, oFwdValid;
  logic [31:0] RegWriteData, Hi, Lo, oFwdData;
  logic [4:0]  RegWriteAddress, oFwdAddr;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] oRetireCount;
`endif

  int total = 0;
  int bad   = 0;

  // Model: the instruction currently held in write-back, whether its data is defined, and the retire count.
  instr_t      m_wb;
  bit          m_known;
  logic [31:0] m_cnt;

  mem_wb_writeback dut (
    .Clk(Clk), .Reset(Reset), .iStall(iStall), .iFlush(iFlush), .iValid(iValid),
    .iRegWrite(iRegWrite), .iMemToReg(iMemToReg), .iRegAddr(iRegAddr),
    .iALUResult(iALUResult), .iMemData(iMemData), .iPCPlus4(iPCPlus4),
    .iHiLoWrite(iHiLoWrite), .iHi(iHi), .iLo(iLo),
    .cRegWrite(cRegWrite), .RegWriteData(RegWriteData), .RegWriteAddress(RegWriteAddress),
    .HiLoWrite(HiLoWrite), .Hi(Hi), .Lo(Lo),
    .oFwdValid(oFwdValid), .oFwdAddr(oFwdAddr), .oFwdData(oFwdData)
`ifdef WB_RETIRE_CNT_EN
    , .oRetireCount(oRetireCount)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic instr_t mk(logic v, logic rw, logic [2:0] sel, logic [4:0] addr,
                                logic [31:0] alu, logic [31:0] mem, logic [31:0] pc,
                                logic hlw, logic [31:0] hi, logic [31:0] lo);
    instr_t t;
    t.valid = v; t.regwrite = rw; t.sel = sel; t.addr = addr; t.alu = alu;
    t.mem = mem; t.pc = pc; t.hlw = hlw; t.hi = hi; t.lo = lo;
    return t;
  endfunction

  function automatic instr_t zero_instr();
    return mk(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endfunction

  // Write-back value derived with plain shifts and masks from the load rules.
  function automatic logic [31:0] wb_val(instr_t t);
    int unsigned off = t.alu % 4;
    logic [31:0] b = (t.mem >> (8 * off)) & 32'h0000_00FF;
    logic [31:0] h = (off >= 2) ? (t.mem >> 16) : (t.mem & 32'h0000_FFFF);
    case (t.sel)
      3'd1:    return t.mem;
      3'd2:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd3:    return h;
      3'd4:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd5:    return b;
      3'd6:    return t.pc + 32'd4;
      default: return t.alu;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic we;
    we = m_wb.valid & m_wb.regwrite & (m_wb.addr != 5'd0);
    check("cRegWrite", {31'd0, cRegWrite}, {31'd0, we});
    check("HiLoWrite", {31'd0, HiLoWrite}, {31'd0, m_wb.valid & m_wb.hlw});
    check("oFwdValid", {31'd0, oFwdValid}, {31'd0, we});
    if (m_known) begin
      check("RegWriteData", RegWriteData, wb_val(m_wb));
      check("RegWriteAddress", {27'd0, RegWriteAddress}, {27'd0, m_wb.addr});
      check("Hi", Hi, m_wb.hi);
      check("Lo", Lo, m_wb.lo);
    end
    check("oFwdAddr", {27'd0, oFwdAddr}, {27'd0, RegWriteAddress});
    check("oFwdData", oFwdData, RegWriteData);
`ifdef WB_RETIRE_CNT_EN
    check("oRetireCount", oRetireCount, m_cnt);
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, then check just after it.
  task automatic step(input instr_t t, input bit stall, input bit flush, input bit rst);
    Reset = rst; iStall = stall; iFlush = flush;
    iValid = t.valid; iRegWrite = t.regwrite; iMemToReg = t.sel; iRegAddr = t.addr;
    iALUResult = t.alu; iMemData = t.mem; iPCPlus4 = t.pc;
    iHiLoWrite = t.hlw; iHi = t.hi; iLo = t.lo;
    @(posedge Clk);
    if (rst) begin
      m_wb = zero_instr(); m_known = 1'b1; m_cnt = 32'd0;
    end else if (flush) begin
      m_wb.valid = 1'b0; m_wb.regwrite = 1'b0; m_wb.hlw = 1'b0; m_known = 1'b0;
    end else if (!stall) begin
      m_wb = t; m_known = 1'b1;
      if (t.valid) m_cnt = m_cnt + 32'd1;
    end
    #1;
    check_all();
  endtask

  initial begin
    instr_t t;
    logic [31:0] lb_s [4];
    logic [31:0] lb_u [4];
    lb_s = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
    lb_u = '{32'h0000_0001, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0080};
    m_wb = zero_instr(); m_known = 1'b0; m_cnt = 32'd0;

    // Reset: all outputs zero.
    step(zero_instr(), 1'b0, 1'b0, 1'b1);
    step(zero_instr(), 1'b0, 1'b0, 1'b1);
    check("rst_data", RegWriteData, 32'd0);
    check("rst_we", {31'd0, cRegWrite}, 32'd0);

    // ALU result write-back with one-cycle latency.
    step(mk(1, 1, 3'b000, 5'd8, 32'h0000_1234, 32'd0, 32'd0, 0, 32'd0, 32'd0), 0, 0, 0);
    check("alu_data", RegWriteData, 32'h0000_1234);
    check("alu_we", {31'd0, cRegWrite}, 32'd1);
    check("alu_addr", {27'd0, RegWriteAddress}, 32'd8);

    // Byte loads, signed and unsigned, across all offsets.
    for (int i = 0; i < 4; i++) begin
      step(mk(1, 1, 3'b100, 5'd3, 32'h1000_0000 + i, 32'h80FF_7F01, 32'd0, 0, 32'd0, 32'd0), 0, 0, 0);
      check("lb", RegWriteData, lb_s[i]);
      step(mk(1, 1, 3'b101, 5'd3, 32'h1000_0000 + i, 32'h80FF_7F01, 32'd0, 0, 32'd0, 32'd0), 0, 0, 0);
      check("lbu", RegWriteData, lb_u[i]);
    end

    // Halfword loads.
    step(mk(1, 1, 3'b010, 5'd4, 32'h0000_0000, 32'h8001_FFFE, 32'd0, 0, 32'd0, 32'd0), 0, 0, 0);
    check("lh0", RegWriteData, 32'hFFFF_FFFE);
    step(mk(1, 1, 3'b010, 5'd4, 32'h0000_0002, 32'h8001_FFFE, 32'd0, 0, 32'd0, 32'd0), 0, 0, 0);
    check("lh2", RegWriteData, 32'hFFFF_8001);
    step(mk(1, 1, 3'b011, 5'd4, 32'h0000_0003, 32'h8001_FFFE, 32'd0, 0, 32'd0, 32'd0), 0, 0, 0);
    check("lhu3", RegWriteData, 32'h0000_8001);

    // Link address wraps; write to $0 suppressed but address still shown.
    step(mk(1, 1, 3'b110, 5'd31, 32'd0, 32'd0, 32'hFFFF_FFFC, 0, 32'd0, 32'd0), 0, 0, 0);
    check("link_wrap", RegWriteData, 32'h0000_0000);
    step(mk(1, 1, 3'b000, 5'd0, 32'h5555_AAAA, 32'd0, 32'd0, 0, 32'd0, 32'd0), 0, 0, 0);
    check("r0_we", {31'd0, cRegWrite}, 32'd0);
    check("r0_addr", {27'd0, RegWriteAddress}, 32'd0);

    // Hi/Lo write held through a 3-cycle stall with different inputs presented.
    step(mk(1, 0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 1, 32'hDEAD_BEEF, 32'h1234_5678), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 1, 3'b001, 5'd9, 32'd7, 32'd9, 32'd0, 1, 32'h1111_1111, 32'h2222_2222), 1, 0, 0);
      check("stall_hlw", {31'd0, HiLoWrite}, 32'd1);
      check("stall_hi", Hi, 32'hDEAD_BEEF);
      check("stall_lo", Lo, 32'h1234_5678);
    end
    // Flush wins over stall.
    step(mk(1, 1, 3'b000, 5'd9, 32'd7, 32'd9, 32'd0, 1, 32'd0, 32'd0), 1, 1, 0);
    check("flush_we", {31'd0, cRegWrite}, 32'd0);
    check("flush_hlw", {31'd0, HiLoWrite}, 32'd0);

    // Reset mid-stream discards the in-flight instruction.
    step(mk(1, 1, 3'b000, 5'd5, 32'hCAFE_0000, 32'd0, 32'd0, 1, 32'd1, 32'd2), 0, 0, 0);
    step(mk(1, 1, 3'b000, 5'd6, 32'hCAFE_0001, 32'd0, 32'd0, 1, 32'd1, 32'd2), 0, 0, 1);
    check("midrst_we", {31'd0, cRegWrite}, 32'd0);
    check("midrst_hlw", {31'd0, HiLoWrite}, 32'd0);

`ifdef WB_RETIRE_CNT_EN
    // 5 valid entries, 1 flushed, 2 stall cycles -> count of 5; then reset clears it.
    t = mk(1, 1, 3'b000, 5'd1, 32'd1, 32'd0, 32'd0, 0, 32'd0, 32'd0);
    step(t, 0, 0, 0); step(t, 0, 0, 0); step(t, 0, 0, 0);
    step(t, 0, 1, 0);
    step(t, 1, 0, 0); step(t, 1, 0, 0);
    step(t, 0, 0, 0); step(t, 0, 0, 0);
    check("retire5", oRetireCount, 32'd5);
    step(t, 0, 0, 1);
    check("retire_rst", oRetireCount, 32'd0);
`endif

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      t.valid    = ($urandom_range(0, 7) != 0);
      t.regwrite = ($urandom_range(0, 3) != 0);
      t.sel      = 3'($urandom_range(0, 7));
      t.addr     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      t.alu      = $urandom;
      t.mem      = $urandom;
      t.pc       = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      t.hlw      = $urandom_range(0, 1) == 1;
      t.hi       = $urandom;
      t.lo       = $urandom;
      step(t, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register plus write-back select logic.
- Drives the register-file and Hi/Lo write inputs that the IF/ID stage consumes: cRegWrite, RegWriteData, RegWriteAddress, Hi, Lo, HiLoWrite.
- Sits between the data-memory stage and the IF/ID combo. Produces the final write-back value from ALU result, load data (byte/half/word, signed/unsigned) or link address.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- ADDR_W, 5, register-file address width.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- iStall  in  1  hold the stage register contents.
- iFlush  in  1  insert a bubble on the next edge.
- iValid  in  1  MEM-stage instruction valid.
- iRegWrite  in  1  instruction writes the GPR file.
- iMemToReg  in  3  write-back source select.
- iRegAddr  in  5  destination register.
- iALUResult  in  32  ALU result; bits [1:0] are also the load byte offset.
- iMemData  in  32  raw word read from data memory.
- iPCPlus4  in  32  PC+4 of the instruction.
- iHiLoWrite  in  1  instruction writes Hi/Lo.
- iHi  in  32  new Hi value.
- iLo  in  32  new Lo value.
- cRegWrite  out  1  GPR write enable.
- RegWriteData  out  32  GPR write data.
- RegWriteAddress  out  5  GPR write address.
- HiLoWrite  out  1  Hi/Lo write enable.
- Hi  out  32  Hi write data.
- Lo  out  32  Lo write data.
- oFwdValid  out  1  forwarding source valid for EX.
- oFwdAddr  out  5  forwarding register address.
- oFwdData  out  32  forwarding data; equals RegWriteData.

Behaviour:
- Stage register update, on each rising Clk, in priority order:
  - Reset: clear all stage registers.
  - else iFlush: clear valid and all control bits; data fields do not care.
  - else iStall: hold all registers.
  - else: latch every input.
- iFlush beats iStall when both are asserted in the same cycle.
- Latency: exactly 1 cycle from MEM inputs to write-back outputs. Outputs are combinational from the stage register only; no input-to-output combinational path.
- Reset values: every output is 0. cRegWrite=0, HiLoWrite=0 and oFwdValid=0 from the cycle after Reset is sampled high.
- cRegWrite = valid & regwrite & (addr != 0). A write to $0 is suppressed but RegWriteAddress still shows 0.
- HiLoWrite = valid & hilowrite. Hi and Lo pass the latched values.
- While iStall holds the register, the write enables stay asserted. The write repeats with identical data, which is idempotent.
- oFwdValid = cRegWrite, oFwdAddr = RegWriteAddress, oFwdData = RegWriteData.
- Load lane selection uses off = ALUResult[1:0]:
  - byte = MemData[8*off+7 : 8*off]
  - half = MemData[15:0] when off[1]=0, else MemData[31:16]; off[0] is ignored for halfword loads.
- MemToReg select:
  - 000: ALU result
  - 001: word (MemData unchanged)
  - 010: half, sign-extended
  - 011: half, zero-extended
  - 100: byte, sign-extended
  - 101: byte, zero-extended
  - 110: PCPlus4 + 4 (link address; the addition wraps modulo 2^32)
  - 111: ALU result (reserved)
- Reset asserted mid-stream: the in-flight instruction is discarded and no write occurs in the following cycle.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output oRetireCount, 32 bits.
  - It increments once per edge on which a valid instruction enters the stage. That is, not Reset, not iFlush, not iStall, and iValid=1.
  - Wraps from 0xFFFFFFFF to 0. Reset clears it to 0.
  - A stalled instruction is counted exactly once.
- When undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, then iValid=1, iRegWrite=1, iRegAddr=8, iMemToReg=000, iALUResult=0x00001234 -> next cycle cRegWrite=1, RegWriteAddress=8, RegWriteData=0x00001234, oFwdValid=1.
- iMemData=0x80FF7F01, iMemToReg=100, iALUResult[1:0] swept 0..3 -> RegWriteData 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Repeat with 101 -> 0x01, 0x7F, 0xFF, 0x80.
- iMemData=0x8001FFFE: iMemToReg=010 with off=0 -> 0xFFFFFFFE; 010 with off=2 -> 0xFFFF8001; 011 with off=2 -> 0x00008001.
- iMemToReg=110, iPCPlus4=0xFFFFFFFC -> RegWriteData=0x00000000. iRegAddr=0 with iRegWrite=1 -> cRegWrite=0.
- iHiLoWrite=1, iHi=0xDEADBEEF, iLo=0x12345678 with iStall=1 for 3 cycles -> HiLoWrite=1 held for 3 cycles with unchanged values. iStall=1 and iFlush=1 together -> next cycle cRegWrite=0 and HiLoWrite=0.
- WB_RETIRE_CNT_EN defined: 5 valid instructions, 1 flushed, 2 stall cycles -> oRetireCount=5. Reset mid-sequence -> 0 on the next cycle.
